// File: rtl/serv_fpu_seq.sv
// Sequencer for the bit-serial FPU datapath on the SERV extension interface.
// Drives operand shift-in, op-dependent execution and result shift-out enables.
module serv_fpu_seq #(
  parameter int W       = 1,
  parameter int LAT_ADD = 4,
  parameter int LAT_MUL = 8,
  parameter int LAT_DIV = 32
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_fpu_valid,
  input  logic [2:0] i_fpu_op,
  input  logic       i_special,
  input  logic       i_flush,
  input  logic       i_cnt_en,
  input  logic       i_cnt_done,
  output logic       o_busy,
  output logic       o_ld_en,
  output logic       o_exec_en,
  output logic [2:0] o_exec_op,
  output logic       o_st_en,
  output logic       o_fpu_ready,
  output logic       o_bypass
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EXEC,
    S_DONE,
    S_WB
  } state_t;

  localparam logic [5:0] LOAD_LAST = 6'(32 / W - 1);
  localparam logic [5:0] ADD_LAST  = 6'(LAT_ADD - 1);
  localparam logic [5:0] MUL_LAST  = 6'(LAT_MUL - 1);
  localparam logic [5:0] DIV_LAST  = 6'(LAT_DIV - 1);

  state_t     r_state;
  state_t     w_next;
  logic [5:0] r_cnt;
  logic [2:0] r_op;
  logic       r_bypass;
  logic [5:0] w_lat_last;
  logic       w_load_last;
  logic       w_exec_last;
  logic       w_accept;

  always_comb begin
    w_lat_last = ADD_LAST;
    case (r_op)
      3'b010:         w_lat_last = MUL_LAST;
      3'b011, 3'b100: w_lat_last = DIV_LAST;
      default:        w_lat_last = ADD_LAST;
    endcase
  end

  assign w_load_last = (r_state == S_LOAD) && (r_cnt == LOAD_LAST);
  assign w_exec_last = (r_state == S_EXEC) && (r_cnt == w_lat_last);
  assign w_accept    = (r_state == S_IDLE) && i_fpu_valid && !i_flush;

  // Flush overrides every transition, including acceptance in IDLE.
  always_comb begin
    w_next = r_state;
    if (i_flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (i_fpu_valid) w_next = S_LOAD;
        S_LOAD: if (w_load_last) w_next = i_special ? S_DONE : S_EXEC;
        S_EXEC: if (w_exec_last) w_next = S_DONE;
        S_DONE: w_next = S_WB;
        S_WB:   if (i_cnt_en && i_cnt_done) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // The beat counter restarts on every state change so LOAD and EXEC share it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_bypass <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_cnt <= '0;
      else if ((r_state == S_LOAD) || (r_state == S_EXEC))
        r_cnt <= r_cnt + 6'd1;
      if (w_accept)
        r_op <= i_fpu_op;
      if (i_flush || w_accept)
        r_bypass <= 1'b0;
      else if (w_load_last)
        r_bypass <= i_special;
    end
  end

  assign o_busy      = (r_state != S_IDLE);
  assign o_ld_en     = (r_state == S_LOAD);
  assign o_exec_en   = (r_state == S_EXEC);
  assign o_st_en     = (r_state == S_WB) && i_cnt_en;
  assign o_fpu_ready = (r_state == S_DONE);
  assign o_exec_op   = r_op;
  assign o_bypass    = r_bypass;

endmodule

// File: doc/serv_fpu_seq.md
Name: serv_fpu_seq

Overview:
- Sequencer for the bit-serial FPU datapath attached to the SERV extension interface.
- Accepts an FPU request from the core state logic and sequences operand shift-in, op-dependent multi-cycle execution and result shift-out.
- Returns a ready strobe that the core uses as its RF write request, the same way the MDU does.
- Sits between the core state/decode logic and the FPU datapath; owns all FPU datapath enables.

Parameters:
W, 1, bits per cycle of the serial datapath (1 or 4); LOAD beats = 32/W
LAT_ADD, 4, EXEC cycles for add/sub/min-max/cmp/cvt
LAT_MUL, 8, EXEC cycles for mul
LAT_DIV, 32, EXEC cycles for div and sqrt (max 63)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
i_fpu_valid  in  1  level request from core (held until o_fpu_ready)
i_fpu_op  in  3  000 add, 001 sub, 010 mul, 011 div, 100 sqrt, 101 minmax, 110 cmp, 111 cvt
i_special  in  1  datapath flags NaN/inf/zero operand; sampled on last LOAD beat
i_flush  in  1  abort current op (trap/irq)
i_cnt_en  in  1  core counter running (stage two)
i_cnt_done  in  1  core counter last beat
o_busy  out  1  state != IDLE
o_ld_en  out  1  operand shift-in enable
o_exec_en  out  1  compute engine enable
o_exec_op  out  3  latched op
o_st_en  out  1  result shift-out enable
o_fpu_ready  out  1  one-cycle result-ready strobe
o_bypass  out  1  latched i_special; result mux selects special-case value

Behaviour:
- Asynchronous reset: state=IDLE, counters=0, op latch=0, bypass=0. All outputs 0 while i_rst is high and on the first edge after release.
- States: IDLE, LOAD, EXEC, DONE, WB.
- IDLE: on i_fpu_valid=1 latch i_fpu_op into o_exec_op, clear bypass, clear cnt, go to LOAD next cycle.
- LOAD:
  - o_ld_en=1 for exactly 32/W cycles, cnt 0..(32/W-1).
  - On the last beat, sample i_special into o_bypass.
  - Next state: DONE if i_special=1, else EXEC with cnt=0.
- EXEC:
  - o_exec_en=1 for exactly LAT(op) cycles.
  - LAT(op): LAT_MUL for op 010; LAT_DIV for 011/100; LAT_ADD otherwise.
  - Go to DONE after the last cycle.
- DONE: o_fpu_ready=1 for exactly one cycle, then WB.
- WB:
  - o_st_en = i_cnt_en.
  - On i_cnt_en & i_cnt_done go to IDLE.
  - i_fpu_valid is ignored in WB; a new op is accepted only from IDLE.
- Latency:
  - Valid-in-IDLE to o_fpu_ready, normal path: 1 + 32/W + LAT(op) cycles. W=1 add: 37.
  - Valid-in-IDLE to o_fpu_ready, bypass path: 1 + 32/W cycles.
- Counter: 6 bits, shared by LOAD and EXEC, reset to 0 at each state entry. Wrap-around never occurs since LAT ≤ 63.
- i_flush:
  - In any state, go to IDLE next cycle and clear o_bypass.
  - Flush on the DONE cycle still lets the ready strobe be seen that cycle; the core must ignore it.
  - Flush has priority over every other transition, including simultaneous i_fpu_valid in IDLE (request not accepted).
- o_exec_op is stable from the cycle after acceptance until return to IDLE.
- Only one of o_ld_en/o_exec_en/o_st_en/o_fpu_ready is high in any cycle.
- Asynchronous reset mid-operation returns to IDLE immediately; no partial outputs after release.

Test Plan:
- W=1, valid with op=000, i_special=0: o_ld_en high cycles 1..32, o_exec_en 33..36, o_fpu_ready at cycle 37 only; then i_cnt_en for 32 cycles with done on last -> o_st_en 32 cycles, o_busy=0 after.
- op=011 (div): o_exec_en exactly 32 cycles, ready at cycle 65; op=010: exec 8 cycles, ready at 41.
- op=000 with i_special=1 on last LOAD beat: no o_exec_en, o_bypass=1, ready at cycle 33.
- i_flush asserted at EXEC cycle 3 of a div: IDLE next cycle, no ready strobe, o_bypass=0; new valid is accepted on the following cycle.
- i_rst pulsed asynchronously mid-LOAD (between edges): all outputs drop to 0 immediately; after release with valid low, stays IDLE.
- i_fpu_valid held high through WB: no re-accept until IDLE is reached; W=4 build: LOAD lasts 8 cycles, add ready at cycle 13.
